exec_decode_unit: RTL and testbench

EXEC_DECODE_UNIT -- requirements
Module: exec_decode_unit

---
 rtl/exec_decode_pkg.sv | 45 ++++
 rtl/exec_alu_core.sv | 33 +++
 rtl/exec_decode_unit.sv | 113 +++++++++++
 tb/tb_exec_decode_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/exec_decode_pkg.sv
// rtl/exec_decode_pkg.sv - shared opcode, ALU op and IR reset constants (ALU_EXT_OPS_EN adds mult/sll/srl)
package exec_decode_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_MULT  = 8'h0C;
  localparam logic [7:0] OP_SLL   = 8'h0D;
  localparam logic [7:0] OP_SRL   = 8'h0E;

  localparam logic [2:0] ALU_FWD  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_MULT = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;

  // Undefined opcode 0xFF so that a freshly reset unit issues no side effects.
  localparam logic [31:0] IR_RESET_VAL = 32'hFF00_0000;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       write_enable;
    logic       twoscomp_sel;
    logic       immed_sel;
    logic       branch_en;
    logic       jump_en;
    logic       writemux_sel;
    logic       mem_write;
    logic       mem_read;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/exec_alu_core.sv
// rtl/exec_alu_core.sv - combinational 8-bit ALU (ALU_EXT_OPS_EN enables mult/sll/srl)
module exec_alu_core
  import exec_decode_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [7:0] result
);

`ifdef ALU_EXT_OPS_EN
  logic [15:0] product;
  assign product = {8'h00, data1} * {8'h00, data2};
`endif

  // Result select; shift amounts come from operand 2, which carries IR[7:0] for immediate ops.
  always_comb begin
    result = 8'h00;
    case (alu_op)
      ALU_FWD: result = data2;
      ALU_ADD: result = data1 + data2;
      ALU_AND: result = data1 & data2;
      ALU_OR:  result = data1 | data2;
`ifdef ALU_EXT_OPS_EN
      ALU_MULT: result = product[7:0];
      ALU_SLL:  result = data1 << data2[2:0];
      ALU_SRL:  result = data1 >> data2[2:0];
`endif
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/exec_decode_unit.sv
// rtl/exec_decode_unit.sv - instruction register, decoder, immediate mux and ALU (ALU_EXT_OPS_EN adds ops 0x0C-0x0E)
module exec_decode_unit
  import exec_decode_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        BUSYWAIT,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  OPERAND2,
  output logic [7:0]  ALURESULT,
  output logic        ZERO,
  output logic [2:0]  ALUOP,
  output logic        WRITEENABLE,
  output logic        TWOSCOMPMUX_SEL,
  output logic        IMMEDMUX_SEL,
  output logic        BRANCHENABLE,
  output logic        JUMPENABLE,
  output logic        WRITEMUX_SEL,
  output logic        WRITE,
  output logic        READ
);

  logic [31:0] ir_q;
  logic [31:0] ir_d;
  ctrl_t       ctrl;
  logic [7:0]  opcode;
  logic [7:0]  alu_op2;
  logic        unused_ir_fields;

  assign opcode           = ir_q[31:24];
  assign unused_ir_fields = ^ir_q[23:8];

  // Capture the next instruction unless memory is stalling the pipeline.
  always_comb begin
    ir_d = ir_q;
    if (!BUSYWAIT) begin
      ir_d = INSTRUCTION;
    end
  end

  // Instruction register; reset wins over both stall and capture.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ir_q <= IR_RESET_VAL;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Opcode decode; anything not listed leaves every control at zero.
  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_LOADI: begin ctrl.alu_op = ALU_FWD; ctrl.write_enable = 1'b1; ctrl.immed_sel = 1'b1; end
      OP_MOV:   begin ctrl.alu_op = ALU_FWD; ctrl.write_enable = 1'b1; end
      OP_ADD:   begin ctrl.alu_op = ALU_ADD; ctrl.write_enable = 1'b1; end
      OP_SUB:   begin ctrl.alu_op = ALU_ADD; ctrl.write_enable = 1'b1; ctrl.twoscomp_sel = 1'b1; end
      OP_AND:   begin ctrl.alu_op = ALU_AND; ctrl.write_enable = 1'b1; end
      OP_OR:    begin ctrl.alu_op = ALU_OR;  ctrl.write_enable = 1'b1; end
      OP_J:     begin ctrl.jump_en = 1'b1; end
      OP_BEQ:   begin ctrl.alu_op = ALU_ADD; ctrl.twoscomp_sel = 1'b1; ctrl.branch_en = 1'b1; end
      OP_LWD: begin
        ctrl.alu_op       = ALU_FWD;
        ctrl.write_enable = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.writemux_sel = 1'b1;
      end
      OP_LWI: begin
        ctrl.alu_op       = ALU_FWD;
        ctrl.write_enable = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.writemux_sel = 1'b1;
        ctrl.immed_sel    = 1'b1;
      end
      OP_SWD:   begin ctrl.alu_op = ALU_FWD; ctrl.mem_write = 1'b1; end
      OP_SWI:   begin ctrl.alu_op = ALU_FWD; ctrl.mem_write = 1'b1; ctrl.immed_sel = 1'b1; end
`ifdef ALU_EXT_OPS_EN
      OP_MULT:  begin ctrl.alu_op = ALU_MULT; ctrl.write_enable = 1'b1; end
      OP_SLL:   begin ctrl.alu_op = ALU_SLL;  ctrl.write_enable = 1'b1; ctrl.immed_sel = 1'b1; end
      OP_SRL:   begin ctrl.alu_op = ALU_SRL;  ctrl.write_enable = 1'b1; ctrl.immed_sel = 1'b1; end
`endif
      default:  ctrl = CTRL_NONE;
    endcase
  end

  // Immediate mux feeding ALU operand 2.
  always_comb begin
    alu_op2 = OPERAND2;
    if (ctrl.immed_sel) begin
      alu_op2 = ir_q[7:0];
    end
  end

  exec_alu_core u_alu (
    .alu_op (ctrl.alu_op),
    .data1  (REGOUT1),
    .data2  (alu_op2),
    .result (ALURESULT)
  );

  assign ZERO            = (ALURESULT == 8'h00);
  assign ALUOP           = ctrl.alu_op;
  assign WRITEENABLE     = ctrl.write_enable;
  assign TWOSCOMPMUX_SEL = ctrl.twoscomp_sel;
  assign IMMEDMUX_SEL    = ctrl.immed_sel;
  assign BRANCHENABLE    = ctrl.branch_en;
  assign JUMPENABLE      = ctrl.jump_en;
  assign WRITEMUX_SEL    = ctrl.writemux_sel;
  assign WRITE           = ctrl.mem_write;
  assign READ            = ctrl.mem_read;

endmodule

// File: tb/tb_exec_decode_unit.sv
// tb/tb_exec_decode_unit.sv - scoreboard bench for exec_decode_unit (ALU_EXT_OPS_EN-aware)
module tb_exec_decode_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
  logic [7:0]  REGOUT1;
  logic [7:0]  OPERAND2;
  logic [7:0]  ALURESULT;
  logic        ZERO;
  logic [2:0]  ALUOP;
  logic        WRITEENABLE;
  logic        TWOSCOMPMUX_SEL;
  logic        IMMEDMUX_SEL;
  logic        BRANCHENABLE;
  logic        JUMPENABLE;
  logic        WRITEMUX_SEL;
  logic        WRITE;
  logic        READ;

  exec_decode_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .INSTRUCTION     (INSTRUCTION),
    .BUSYWAIT        (BUSYWAIT),
    .REGOUT1         (REGOUT1),
    .OPERAND2        (OPERAND2),
    .ALURESULT       (ALURESULT),
    .ZERO            (ZERO),
    .ALUOP           (ALUOP),
    .WRITEENABLE     (WRITEENABLE),
    .TWOSCOMPMUX_SEL (TWOSCOMPMUX_SEL),
    .IMMEDMUX_SEL    (IMMEDMUX_SEL),
    .BRANCHENABLE    (BRANCHENABLE),
    .JUMPENABLE      (JUMPENABLE),
    .WRITEMUX_SEL    (WRITEMUX_SEL),
    .WRITE           (WRITE),
    .READ            (READ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [10:0] ctrl;
    logic [7:0] res;
    logic       zero;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ir_m;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode + ALU; ctrl = {aluop,we,tc,imm,br,jmp,wmux,wr,rd}.
  function automatic exp_t model(input string tag, input logic [31:0] ir,
                                 input logic [7:0] r1, input logic [7:0] op2);
    exp_t        e;
    logic [2:0]  a = 3'b000;
    logic        we = 0, tc = 0, imm = 0, br = 0, jmp = 0, wm = 0, wr = 0, rd = 0;
    logic [7:0]  b;
    logic [15:0] p;
    case (ir[31:24])
      8'h00: begin we = 1; imm = 1; end
      8'h01: begin we = 1; end
      8'h02: begin a = 3'b001; we = 1; end
      8'h03: begin a = 3'b001; we = 1; tc = 1; end
      8'h04: begin a = 3'b010; we = 1; end
      8'h05: begin a = 3'b011; we = 1; end
      8'h06: begin jmp = 1; end
      8'h07: begin a = 3'b001; tc = 1; br = 1; end
      8'h08: begin we = 1; rd = 1; wm = 1; end
      8'h09: begin we = 1; rd = 1; wm = 1; imm = 1; end
      8'h0A: begin wr = 1; end
      8'h0B: begin wr = 1; imm = 1; end
`ifdef ALU_EXT_OPS_EN
      8'h0C: begin a = 3'b100; we = 1; end
      8'h0D: begin a = 3'b101; we = 1; imm = 1; end
      8'h0E: begin a = 3'b110; we = 1; imm = 1; end
`endif
      default: ;
    endcase
    b = imm ? ir[7:0] : op2;
    p = {8'h00, r1} * {8'h00, b};
    case (a)
      3'b000: e.res = b;
      3'b001: e.res = r1 + b;
      3'b010: e.res = r1 & b;
      3'b011: e.res = r1 | b;
      3'b100: e.res = p[7:0];
      3'b101: e.res = r1 << ir[2:0];
      3'b110: e.res = r1 >> ir[2:0];
      default: e.res = 8'h00;
    endcase
    e.tag  = tag;
    e.ctrl = {a, we, tc, imm, br, jmp, wm, wr, rd};
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
  task automatic apply(input string tag, input logic rst, input logic busy,
                       input logic [31:0] instr, input logic [7:0] r1, input logic [7:0] op2);
    @(negedge CLK);
    RESET       = rst;
    BUSYWAIT    = busy;
    INSTRUCTION = instr;
    REGOUT1     = r1;
    OPERAND2    = op2;
    if (!rst) ir_m = 32'hFF00_0000;
    else if (!busy) ir_m = instr;
    sb_q.push_back(model(tag, ir_m, r1, op2));
  endtask

  // Monitor: compare against the oldest queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq({e.tag, ".ctrl"}, {21'd0, ALUOP, WRITEENABLE, TWOSCOMPMUX_SEL, IMMEDMUX_SEL,
                 BRANCHENABLE, JUMPENABLE, WRITEMUX_SEL, WRITE, READ}, {21'd0, e.ctrl});
        check_eq({e.tag, ".res"}, {24'd0, ALURESULT}, {24'd0, e.res});
        check_eq({e.tag, ".zero"}, {31'd0, ZERO}, {31'd0, e.zero});
      end
    end
  end

  initial begin
    int wait_cycles;
    RESET = 1'b0; BUSYWAIT = 1'b0; INSTRUCTION = 32'h0; REGOUT1 = 8'h0; OPERAND2 = 8'h0;
    ir_m = 32'hFF00_0000;

    apply("reset",      1'b0, 1'b1, 32'h0200_0000, 8'h11, 8'h22);
    check_eq("reset_aluop", 32'(ALUOP), 32'd0);
    apply("loadi",      1'b1, 1'b0, 32'h0004_002A, 8'h00, 8'h00);
    apply("sub_eq",     1'b1, 1'b0, 32'h0301_0200, 8'h05, 8'hFB);
    apply("add_wrap",   1'b1, 1'b0, 32'h0201_0200, 8'hFF, 8'h02);
    apply("and",        1'b1, 1'b0, 32'h0402_0100, 8'hF0, 8'h3C);
    apply("or",         1'b1, 1'b0, 32'h0502_0100, 8'hF0, 8'h0C);
    apply("mov",        1'b1, 1'b0, 32'h0103_0000, 8'h99, 8'h00);
    apply("beq",        1'b1, 1'b0, 32'h0700_0102, 8'h40, 8'hC0);
    apply("lwd",        1'b1, 1'b0, 32'h0805_0300, 8'h00, 8'h77);
    for (int i = 0; i < 3; i++)
      apply("lwd_stall", 1'b1, 1'b1, 32'h0A00_0000 + 32'(i), 8'h00, 8'h77);
    apply("swd",        1'b1, 1'b0, 32'h0A00_0102, 8'h00, 8'h55);
    apply("lwi",        1'b1, 1'b0, 32'h0901_0044, 8'h00, 8'h00);
    apply("swi",        1'b1, 1'b0, 32'h0B00_0112, 8'h00, 8'h00);
    apply("jump",       1'b1, 1'b0, 32'h0600_0004, 8'h00, 8'h00);
    apply("op0c",       1'b1, 1'b0, 32'h0C01_0200, 8'h07, 8'h03);
    apply("op0d",       1'b1, 1'b0, 32'h0D01_0203, 8'h13, 8'h00);
    apply("op0e",       1'b1, 1'b0, 32'h0E01_0202, 8'hC8, 8'h00);
    apply("undef",      1'b1, 1'b0, 32'h3F01_02FF, 8'h12, 8'h34);
    apply("swd_pre",    1'b1, 1'b0, 32'h0A00_0000, 8'h00, 8'h00);
    apply("rst_prio",   1'b0, 1'b0, 32'h0300_0000, 8'h05, 8'hFB);
    apply("rst_busy",   1'b0, 1'b1, 32'h0800_0000, 8'h00, 8'h00);
    for (int i = 0; i < 40; i++)
      apply("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
            {8'($urandom_range(0, 15)), 24'($urandom)}, 8'($urandom), 8'($urandom));

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge CLK);
      wait_cycles++;
    end
    #2;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
